// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the loader state enum, frame sync marker, baud and timeout constants.
package uart_prog_pkg;

   typedef enum logic [2:0] {
      WAIT_SYNC,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM
   } state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         BAUD_CYC    = 5000;
   localparam int         TIMEOUT_CYC = 240000;

endpackage

// File: rtl/uart_byte_strobe.sv
// Byte-complete detector on the UART receiver idle flag.
// Ports: clk, rst_n, rx_data/rx_idle in; byte_stb pulse and byte_q out.
module uart_byte_strobe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_idle,
   output logic       byte_stb,
   output logic [7:0] byte_q
);
   import uart_prog_pkg::*;

   logic idle_d;

   // Resetting to 1 means an idle line after reset is not a new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_d <= 1'b1;
      else        idle_d <= rx_idle;
   end

   assign byte_stb = rx_idle & ~idle_d;
   assign byte_q   = rx_data;

endmodule

// File: rtl/uart_prog_loader.sv
// Parses sync/count/data/checksum frames and writes program memory.
// Ports: clk, rst_n, rx_data, rx_idle in; mem_addr/data/we, busy, done, err out.
module uart_prog_loader #(
   parameter int         WORD_BYTES  = 2,
   parameter int         ADDR_W      = 8,
   parameter logic [7:0] SYNC_BYTE   = uart_prog_pkg::SYNC_BYTE,
   parameter int         TIMEOUT_CYC = uart_prog_pkg::TIMEOUT_CYC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_idle,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_data,
   output logic                    mem_we,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   import uart_prog_pkg::*;

   localparam int W  = 8 * WORD_BYTES;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   logic              byte_stb;
   logic [7:0]        byte_q;
   state_t            state;
   logic [7:0]        len_hi;
   logic [ADDR_W:0]   wcnt;
   logic [ADDR_W-1:0] addr;
   logic [BW-1:0]     bidx;
   logic [W-9:0]      wreg;
   logic [7:0]        xsum;
   logic [TW-1:0]     tcnt;

   logic [15:0]       len_full;
   logic              len_bad;
   logic [W-1:0]      word_nx;
   logic              tmo;
   logic              last_b;

   uart_byte_strobe u_stb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_idle  (rx_idle),
      .byte_stb (byte_stb),
      .byte_q   (byte_q)
   );

   assign len_full = {len_hi, byte_q};
   assign len_bad  = (len_full == 16'd0) ||
                     (32'(len_full) > (32'd1 << ADDR_W));
   assign word_nx  = {wreg, byte_q};
   assign last_b   = (bidx == BW'(WORD_BYTES - 1));
   // A strobe in the same cycle beats the timeout.
   assign tmo      = (state != WAIT_SYNC) && !byte_stb &&
                     (tcnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_SYNC;
         mem_addr <= '0;
         mem_data <= '0;
         mem_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         len_hi   <= '0;
         wcnt     <= '0;
         addr     <= '0;
         bidx     <= '0;
         wreg     <= '0;
         xsum     <= '0;
         tcnt     <= '0;
      end else begin
         mem_we <= 1'b0;
         if (byte_stb || state == WAIT_SYNC) tcnt <= '0;
         else                                tcnt <= tcnt + 1'b1;

         if (tmo) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= WAIT_SYNC;
         end else if (byte_stb) begin
            unique case (state)
               WAIT_SYNC: begin
                  if (byte_q == SYNC_BYTE) begin
                     done  <= 1'b0;
                     err   <= 1'b0;
                     busy  <= 1'b1;
                     xsum  <= '0;
                     state <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  len_hi <= byte_q;
                  xsum   <= xsum ^ byte_q;
                  state  <= LEN_LO;
               end
               LEN_LO: begin
                  xsum <= xsum ^ byte_q;
                  if (len_bad) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= WAIT_SYNC;
                  end else begin
                     wcnt  <= len_full[ADDR_W:0];
                     addr  <= '0;
                     bidx  <= '0;
                     state <= DATA;
                  end
               end
               DATA: begin
                  xsum <= xsum ^ byte_q;
                  wreg <= word_nx[W-9:0];
                  if (last_b) begin
                     mem_data <= word_nx;
                     mem_addr <= addr;
                     mem_we   <= 1'b1;
                     addr     <= addr + 1'b1;
                     wcnt     <= wcnt - 1'b1;
                     bidx     <= '0;
                     if (wcnt == (ADDR_W+1)'(1)) state <= CSUM;
                  end else begin
                     bidx <= bidx + 1'b1;
                  end
               end
               CSUM: begin
                  if (byte_q == xsum) done <= 1'b1;
                  else                err  <= 1'b1;
                  busy  <= 1'b0;
                  state <= WAIT_SYNC;
               end
               default: state <= WAIT_SYNC;
            endcase
         end
      end
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Downstream consumer of the UART byte receiver in the programming path.
- Watches the receiver's parallel byte output and idle flag, and parses a framed download: sync, word count, data bytes, checksum.
- Assembles bytes into memory words and issues write strobes to program memory.
- Reports busy/done/error so the CPU can be held in reset while a program loads.

Parameters:
- WORD_BYTES, 2, bytes per memory word (data word width = 8*WORD_BYTES).
- ADDR_W, 8, program memory address width. Maximum load is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 240000, maximum clock cycles between bytes inside a frame (5 ms at 48 MHz).

Ports:
- CLK  input  1  system clock (48 MHz).
- RST_N  input  1  asynchronous, active-low reset.
- RX_DATA  input  8  byte from the UART receiver; valid when RX_IDLE rises.
- RX_IDLE  input  1  receiver idle flag; a 0->1 transition marks a completed byte.
- MEM_ADDR  output  ADDR_W  program memory write address.
- MEM_DATA  output  8*WORD_BYTES  program memory write data.
- MEM_WE  output  1  one-cycle write strobe.
- BUSY  output  1  high while a frame is being received (any state other than WAIT_SYNC).
- DONE  output  1  sticky; last frame completed with a good checksum.
- ERR  output  1  sticky; last frame aborted (bad length, bad checksum, or timeout).

Behaviour:
- Reset (async assert, sync release) values: MEM_ADDR=0, MEM_DATA=0, MEM_WE=0, BUSY=0, DONE=0, ERR=0, state=WAIT_SYNC.
  - The internal idle_d register resets to 1, so no false strobe occurs after reset.
- Byte strobe: byte_stb = RX_IDLE & ~idle_d, where idle_d is RX_IDLE registered.
  - RX_DATA is sampled in the strobe cycle.
  - A level-high RX_IDLE never produces a second strobe.
- Frame format, MSB first throughout:
  - SYNC.
  - N_HI, N_LO (word count N).
  - N*WORD_BYTES data bytes.
  - CSUM = XOR of every byte after SYNC (count bytes and data bytes).
- States and transitions:
  - WAIT_SYNC: on a strobe with SYNC_BYTE, clear DONE/ERR, set BUSY, clear the running XOR, go to LEN_HI. Other bytes are ignored.
  - LEN_HI: latch N[15:8] -> LEN_LO.
  - LEN_LO: latch N[7:0].
    - N==0 or N>2^ADDR_W: ERR=1 -> WAIT_SYNC.
    - Otherwise: word counter = N, address = 0, byte index = 0 -> DATA.
  - DATA: shift the byte into the word assembly register.
    - When the last byte of a word arrives: MEM_DATA=word, MEM_ADDR=current address, MEM_WE=1 in the next cycle only. Then the address increments and the word counter decrements.
    - When the word counter reaches 0: -> CSUM.
  - CSUM: received byte == running XOR sets DONE=1; otherwise ERR=1. Then -> WAIT_SYNC.
- Write latency: MEM_WE is high exactly one CLK cycle, the cycle after the strobe that completes the word. MEM_ADDR and MEM_DATA hold their values until the next write.
- Writes are not rolled back on checksum or timeout failure. ERR tells the system not to release the CPU.
- Timeout: a counter is cleared on every strobe and increments every cycle in LEN_HI, LEN_LO, DATA and CSUM.
  - Reaching TIMEOUT_CYC sets ERR=1 and returns to WAIT_SYNC; a partial word is discarded.
  - The counter is inactive in WAIT_SYNC.
- SYNC_BYTE inside a frame is treated as ordinary data; there is no resync mid-frame.
- Address width: with N=2^ADDR_W, the final increment wraps MEM_ADDR to 0 after the last write. This is legal; no write follows it.
- Reset mid-frame: all state clears immediately and MEM_WE drops asynchronously.

Decomposition:
- Shared package uart_prog_pkg holds:
  - the state enum (WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM);
  - SYNC_BYTE;
  - the baud constant 5000 (48 MHz / 9600) and TIMEOUT_CYC.
- One natural sub-module, uart_byte_strobe: RX_IDLE edge detect plus RX_DATA capture register, producing byte_stb/byte_q.
- The FSM, assembly, address and checksum logic stay in uart_prog_loader.

Test Plan (ADDR_W=8, WORD_BYTES=2; bytes driven through the RX_DATA/RX_IDLE model at 5000 cycles per bit):
- Good frame A5 00 02 12 34 56 78 0A -> two writes: (addr 0, 0x1234), then (addr 1, 0x5678). MEM_WE is one cycle each. Final state: DONE=1, ERR=0, BUSY=0.
- Same frame with CSUM 0x0B -> both writes occur; ERR=1, DONE=0.
- Length error: A5 00 00, and separately A5 01 01 -> no MEM_WE; ERR=1 right after N_LO; the next A5 frame clears ERR.
- Timeout: A5 00 01 12, then RX_IDLE held 1 for 240000 cycles -> ERR=1, BUSY=0, no write.
- Noise and edge cases:
  - Bytes 00 FF before A5 are ignored.
  - A 0xA5 data byte inside a frame is written as data (frame A5 00 01 A5 A5 01 -> write 0xA5A5, DONE=1).
- RST_N pulsed low mid-DATA -> all outputs 0 immediately; a following full good frame loads from address 0.
